// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Holds the response record and the fetch-address legality check.
package imem_pkg;

  localparam int MAX_OUT_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  // A fetch is illegal when it is not word aligned or lies above the memory.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth_log2);
    logic [31:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/imem_responder_fifo.sv
// In-order response buffer for imem_responder.
// A write on the flush edge survives as the only entry; everything older is dropped.
module resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  wr_en,
  input  resp_t wr_data,
  input  logic  rd_ready,
  output logic  rd_valid,
  output resp_t rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  resp_t         store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Empty buffer presents zeros so idle outputs stay clean.
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? store[rd_ptr] : '0;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= wr_en ? ptr_inc('0) : '0;
      count  <= wr_en ? CW'(1) : '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) store[flush ? '0 : wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Read-only instruction memory with a valid/ready fetch interface,
// configurable latency, bounded outstanding requests and redirect flush.
module imem_responder
  import imem_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    LATENCY    = 1,
  parameter int    MAX_OUT    = MAX_OUT_DEFAULT,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int OW = $clog2(MAX_OUT + 1);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  resp_t                 rd_p0;
  resp_t                 push_data;
  resp_t                 head;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         outstanding_nxt;

  // Stage 0: request accepted, memory read and legality check in the same cycle.
  assign accept = req_valid && req_ready && !rst;
  assign pop    = resp_valid && resp_ready;
  assign idx    = req_addr[DEPTH_LOG2+1:2];

  always_comb begin
    rd_p0.err  = addr_bad(req_addr, DEPTH_LOG2);
    rd_p0.data = rd_p0.err ? 32'd0 : mem[idx];
  end

  // Stages 1..LATENCY-1: delay line into the response buffer.
  if (LATENCY == 1) begin : g_direct
    assign push      = accept;
    assign push_data = rd_p0;
  end else begin : g_chain
    localparam int N = LATENCY - 1;
    logic  vld_p  [N];
    resp_t data_p [N];

    always_ff @(posedge clk) begin
      vld_p[0]  <= accept;
      data_p[0] <= rd_p0;
      for (int i = 1; i < N; i++) begin
        vld_p[i]  <= vld_p[i-1] && !flush && !rst;
        data_p[i] <= data_p[i-1];
      end
    end

    // The request in flight at a flush edge is stale and must not land.
    assign push      = vld_p[N-1] && !flush;
    assign push_data = data_p[N-1];
  end

  resp_fifo #(
    .DEPTH(MAX_OUT)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_ready(resp_ready),
    .rd_valid(resp_valid),
    .rd_data (head)
  );

  assign resp_data = head.data;
  assign resp_err  = head.err;

  // Credit tracking: only the redirected fetch survives a flush.
  assign outstanding_nxt = flush ? OW'(accept)
                                 : outstanding + OW'(accept) - OW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      req_ready   <= 1'b1;
    end else begin
      outstanding <= outstanding_nxt;
      req_ready   <= (outstanding_nxt < OW'(MAX_OUT));
    end
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, sets the memory word-address width (1024 x 32-bit words).
REQ-002 Parameter LATENCY, default 1, range 1..4, sets the request-to-response latency in cycles.
REQ-003 Parameter MAX_OUT, default 4, sets the maximum number of outstanding requests.
REQ-004 Parameter INIT_FILE, default "" (empty string), names the hex file used for preload.
REQ-005 Port clk, input, 1 bit, is the single clock; every register updates on the rising edge.
REQ-006 Port rst, input, 1 bit, is the reset; it SHALL be synchronous and active-high.
REQ-007 Port req_valid, input, 1 bit, means the fetch stage presents an address.
REQ-008 Port req_ready, output, 1 bit, means the responder can accept a request.
REQ-009 Port req_addr, input, 32 bits, carries the byte address (the PC).
REQ-010 Port flush, input, 1 bit, carries a branch/redirect kill.
REQ-011 Port resp_valid, output, 1 bit, means a response is available.
REQ-012 Port resp_ready, input, 1 bit, means the fetch stage consumes the response.
REQ-013 Port resp_data, output, 32 bits, carries the instruction word.
REQ-014 Port resp_err, output, 1 bit, flags a misaligned or out-of-range fetch.

Function
REQ-015 A request SHALL be accepted on any rising edge where req_valid=1 and req_ready=1.
REQ-016 req_ready SHALL be (outstanding < MAX_OUT), driven from a register; it SHALL NOT depend combinationally on resp_ready, req_valid or flush.
REQ-017 The outstanding counter SHALL count accepted requests whose responses have not yet been popped or flushed. It SHALL be +1 on accept, -1 on pop (resp_valid & resp_ready), and unchanged when both occur in the same cycle.
REQ-018 For a request accepted at edge t, the response SHALL enter the response buffer at edge t+LATENCY-1, so resp_valid is visible in the cycle after edge t+LATENCY-1 when the buffer ahead of it is empty.
REQ-019 Responses SHALL be returned strictly in acceptance order.
REQ-020 The memory word index SHALL be req_addr[DEPTH_LOG2+1:2].
REQ-021 resp_err SHALL be 1 and resp_data 0 when req_addr[1:0] != 0 or req_addr[31:DEPTH_LOG2+2] != 0; otherwise resp_err=0 and resp_data=mem[index].
REQ-022 While resp_valid=1 and resp_ready=0, resp_valid, resp_data and resp_err SHALL hold stable.
REQ-023 The response buffer depth SHALL equal MAX_OUT and SHALL never overflow; overflow or underflow is a design error.
REQ-024 On an edge with flush=1, all in-flight and buffered responses SHALL be discarded, resp_valid SHALL be 0 in the following cycle, and outstanding SHALL become 0 plus 1 if a request is accepted on that same edge.
REQ-025 A request accepted on the flush edge SHALL be kept and returned normally, because it is the redirected fetch.
REQ-026 A pop coinciding with flush SHALL complete for the currently presented response; nothing else survives except the REQ-025 request.
REQ-027 When INIT_FILE is non-empty, memory SHALL be preloaded from it as hex words at elaboration; the block has no write port.

Reset
REQ-028 While rst=1 at an edge, outstanding=0, all pipeline valid bits=0, buffer pointers=0, resp_valid=0, resp_data=0, resp_err=0 and req_ready=1 (next cycle).
REQ-029 Reset mid-operation SHALL drop every pending response with no late resp_valid; requests presented during reset SHALL NOT be accepted.
REQ-030 Memory contents SHALL NOT be affected by reset.

Structure
REQ-031 Package imem_pkg SHALL hold the MAX_OUT default, the resp_t struct {data[31:0], err}, and the address-check function.
REQ-032 Sub-module resp_fifo (synchronous, parameterised depth, with flush clear) SHALL implement the response buffer; the latency stage is a valid/payload shift chain in imem_responder.

Verification
REQ-033 With mem[0..3]=0x44707fff,0,0x4413ffff,0x0487b400, LATENCY=1 and resp_ready=1, issue back-to-back addresses 0,4,8,12 -> resp_data in order one cycle after each accept, resp_err=0.
REQ-034 Holding resp_ready=0, issue 5 requests -> exactly 4 accepted, req_ready=0 after the 4th; release resp_ready -> 4 responses in order, then req_ready=1.
REQ-035 Addresses 0x2 and 0x1000 (DEPTH_LOG2=10) -> resp_err=1 and resp_data=0 for each; a following address 0x8 returns 0x4413ffff.
REQ-036 LATENCY=3, accept 0x0 and 0x4, then assert flush with a request to 0xC on the same edge -> only 0x0487b400 is returned, and outstanding reads 1 after the flush edge.
REQ-037 Assert rst for one cycle with 3 outstanding -> resp_valid=0 for all later cycles until a new accept, req_ready=1 the cycle after reset.
REQ-038 Random req_valid/resp_ready/flush run of 10k cycles against a reference queue model -> no ordering, hold-stability or counter mismatch.
